// File: rtl/cint_div_pkg.sv
// Shared types and elaboration-time helpers for the constant-divisor stream divider.
// The digit lookup table is computed entirely from parameters, so it reduces to constant logic.
package cint_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // The carry is a partial remainder, so it never reaches the divisor value.
  function automatic int carry_width(input int divisor);
    return $clog2(divisor);
  endfunction

  // One table entry: {carry, slice} / divisor -> {quotient digit [63:32], new carry [31:0]}.
  function automatic logic [63:0] lut_entry(input int divisor, input int radix_bits,
                                            input int carry, input int slice);
    logic [31:0] value;
    logic [31:0] q;
    logic [31:0] r;
    value = 32'(carry * (2 ** radix_bits) + slice);
    q     = value / 32'(divisor);
    r     = value % 32'(divisor);
    return {q, r};
  endfunction

endpackage

// File: rtl/cint_div_digit.sv
// Combinational radix-2^RADIX_BITS digit step for a constant divisor:
// {carry, slice} -> {quotient digit, new carry}.
module cint_div_digit
  import cint_div_pkg::*;
#(
  parameter int DIVISOR    = 10,
  parameter int RADIX_BITS = 4,
  parameter int CW         = carry_width(DIVISOR)
) (
  input  logic [CW-1:0]         carry_i,
  input  logic [RADIX_BITS-1:0] slice_i,
  output logic [RADIX_BITS-1:0] qdigit_o,
  output logic [CW-1:0]         carry_o
);

  localparam int LUT_DEPTH = 2 ** (CW + RADIX_BITS);

  logic [RADIX_BITS+CW-1:0] lut [LUT_DEPTH];

  // Entries with carry >= DIVISOR are unreachable; their digit is simply truncated.
  for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_lut
    localparam logic [63:0] ENTRY =
      lut_entry(DIVISOR, RADIX_BITS, gi / (2 ** RADIX_BITS), gi % (2 ** RADIX_BITS));
    assign lut[gi] = {ENTRY[32 +: RADIX_BITS], ENTRY[0 +: CW]};
  end

  assign {qdigit_o, carry_o} = lut[{carry_i, slice_i}];

endmodule

// File: rtl/cint_div_stream.sv
// Streaming divide-by-constant: signed/unsigned dividend, RADIX_BITS quotient bits per
// BUSY cycle starting at the highest non-zero slice, valid/ready on both sides.
module cint_div_stream
  import cint_div_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DIVISOR    = 10,
  parameter int RADIX_BITS = 4,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     dividend_i,
  input  logic                 signed_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     quotient_o,
  output logic [WIDTH-1:0]     remainder_o,
  output logic [TAG_WIDTH-1:0] tag_o
);

  localparam int CW      = carry_width(DIVISOR);
  localparam int N_SLICE = (WIDTH + RADIX_BITS - 1) / RADIX_BITS;
  localparam int PW      = N_SLICE * RADIX_BITS;
  localparam int IDXW    = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;

  if (DIVISOR < 2 || RADIX_BITS < 1 || DIVISOR >= 2 ** (WIDTH - 1)) begin : g_bad_params
    $error("cint_div_stream: need DIVISOR>=2, RADIX_BITS>=1, DIVISOR<2**(WIDTH-1)");
  end

  state_e                state_q, state_d;
  logic [PW-1:0]         mag_q, mag_d;
  logic [PW-1:0]         quot_q, quot_d;
  logic [CW-1:0]         carry_q, carry_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic                  neg_q, neg_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [WIDTH-1:0]      quotient_q, quotient_d;
  logic [WIDTH-1:0]      remainder_q, remainder_d;
  logic [TAG_WIDTH-1:0]  tag_out_q, tag_out_d;

  logic                  in_neg;
  logic [PW-1:0]         in_mag;
  logic [N_SLICE-1:0]    in_slice_nz;
  logic [IDXW-1:0]       in_top_idx;
  logic [RADIX_BITS-1:0] slices [N_SLICE];
  logic [RADIX_BITS-1:0] qdigit;
  logic [CW-1:0]         carry_next;
  logic [WIDTH-1:0]      q_mag;
  logic [WIDTH-1:0]      r_mag;
  logic                  accept;

  // Negating the most-negative value wraps back to itself, which is the correct magnitude.
  assign in_neg = signed_i & dividend_i[WIDTH-1];
  assign in_mag = PW'(in_neg ? (~dividend_i + WIDTH'(1)) : dividend_i);

  for (genvar gi = 0; gi < N_SLICE; gi++) begin : g_slice
    assign in_slice_nz[gi] = |in_mag[gi*RADIX_BITS +: RADIX_BITS];
    assign slices[gi]      = mag_q[gi*RADIX_BITS +: RADIX_BITS];
  end

  always_comb begin
    in_top_idx = '0;
    for (int i = 0; i < N_SLICE; i++) begin
      if (in_slice_nz[i]) in_top_idx = IDXW'(i);
    end
  end

  cint_div_digit #(
    .DIVISOR    (DIVISOR),
    .RADIX_BITS (RADIX_BITS),
    .CW         (CW)
  ) u_digit (
    .carry_i  (carry_q),
    .slice_i  (slices[idx_q]),
    .qdigit_o (qdigit),
    .carry_o  (carry_next)
  );

  assign in_ready_o  = ~flush_i & ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & out_ready_i));
  assign accept      = in_valid_i & in_ready_o;
  assign out_valid_o = (state_q == ST_HOLD);
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign tag_o       = tag_out_q;

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    quot_d      = quot_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    neg_d       = neg_q;
    tag_d       = tag_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    tag_out_d   = tag_out_q;
    q_mag       = '0;
    r_mag       = '0;

    case (state_q)
      ST_BUSY: begin
        // Digits arrive most-significant first, so the quotient shifts in from the bottom.
        quot_d  = (quot_q << RADIX_BITS) | PW'(qdigit);
        carry_d = carry_next;
        if (idx_q == '0) begin
          q_mag       = quot_d[WIDTH-1:0];
          r_mag       = WIDTH'(carry_next);
          quotient_d  = neg_q ? (~q_mag + WIDTH'(1)) : q_mag;
          remainder_d = neg_q ? (~r_mag + WIDTH'(1)) : r_mag;
          tag_out_d   = tag_q;
          state_d     = ST_HOLD;
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      mag_d   = in_mag;
      quot_d  = '0;
      carry_d = '0;
      idx_d   = in_top_idx;
      neg_d   = in_neg;
      tag_d   = tag_i;
      state_d = ST_BUSY;
    end

    if (flush_i) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      mag_q       <= '0;
      quot_q      <= '0;
      carry_q     <= '0;
      idx_q       <= '0;
      neg_q       <= 1'b0;
      tag_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      tag_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      quot_q      <= quot_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      neg_q       <= neg_d;
      tag_q       <= tag_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      tag_out_q   <= tag_out_d;
    end
  end

endmodule

// File: tb/tb_cint_div_stream.sv
// Directed bench for cint_div_stream (WIDTH=16, DIVISOR=10, RADIX_BITS=4): a vector table
// of hand-computed results plus hold/back-to-back, flush and mid-operation reset sequences.
module tb_cint_div_stream;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [15:0] dividend_i = '0;
  logic        signed_i = 1'b0;
  logic [3:0]  tag_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [15:0] quotient_o;
  logic [15:0] remainder_o;
  logic [3:0]  tag_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  cint_div_stream #(
    .WIDTH      (16),
    .DIVISOR    (10),
    .RADIX_BITS (4),
    .TAG_WIDTH  (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .dividend_i  (dividend_i),
    .signed_i    (signed_i),
    .tag_i       (tag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .tag_o       (tag_o)
  );

  typedef struct {
    logic [15:0] dividend;
    logic        sgn;
    logic [3:0]  tag;
    logic [15:0] q;
    logic [15:0] r;
    int          k;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Counts edges after the accept edge until out_valid_o rises (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid_o && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic do_op(input vec_t v, input int id);
    int n;
    dividend_i  = v.dividend;
    signed_i    = v.sgn;
    tag_i       = v.tag;
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    check($sformatf("v%0d in_ready", id), 32'(in_ready_o), 32'd1);
    step();
    in_valid_i = 1'b0;
    wait_valid(n);
    check($sformatf("v%0d latency", id), 32'(n), 32'(v.k));
    check($sformatf("v%0d quotient", id), 32'(quotient_o), 32'(v.q));
    check($sformatf("v%0d remainder", id), 32'(remainder_o), 32'(v.r));
    check($sformatf("v%0d tag", id), 32'(tag_o), 32'(v.tag));
    step();
    check($sformatf("v%0d idle", id), 32'(out_valid_o), 32'd0);
  endtask

  initial begin
    int n;
    // latency k = edges after the accept edge = 1 + index of highest non-zero nibble
    vecs[0]  = '{16'd1234,  1'b0, 4'h1, 16'd123,  16'd4,  3};
    vecs[1]  = '{16'h8000,  1'b1, 4'h2, 16'hF334, 16'hFFF8, 4};
    vecs[2]  = '{16'hFFF9,  1'b1, 4'h3, 16'd0,    16'hFFF9, 1};
    vecs[3]  = '{16'd0,     1'b0, 4'h4, 16'd0,    16'd0,  1};
    vecs[4]  = '{16'd65535, 1'b0, 4'h5, 16'd6553, 16'd5,  4};
    vecs[5]  = '{16'hFFF9,  1'b0, 4'h6, 16'd6552, 16'd9,  4};
    vecs[6]  = '{16'd100,   1'b1, 4'h7, 16'd10,   16'd0,  2};
    vecs[7]  = '{16'hFB2E,  1'b1, 4'h8, 16'hFF85, 16'hFFFC, 3};
    vecs[8]  = '{16'd9,     1'b0, 4'h9, 16'd0,    16'd9,  1};
    vecs[9]  = '{16'd16,    1'b0, 4'hA, 16'd1,    16'd6,  2};
    vecs[10] = '{16'h7FFF,  1'b1, 4'hB, 16'h0CCC, 16'd7,  4};

    // Reset state
    step();
    step();
    check("rst out_valid", 32'(out_valid_o), 32'd0);
    check("rst quotient", 32'(quotient_o), 32'd0);
    check("rst remainder", 32'(remainder_o), 32'd0);
    check("rst tag", 32'(tag_o), 32'd0);
    rst_ni = 1'b1;
    step();
    check("rst in_ready", 32'(in_ready_o), 32'd1);

    for (int i = 0; i < 11; i++) do_op(vecs[i], i);

    // Hold with out_ready low, new operand waiting, then same-cycle handoff
    dividend_i  = 16'd1234;
    signed_i    = 1'b0;
    tag_i       = 4'h5;
    in_valid_i  = 1'b1;
    out_ready_i = 1'b0;
    step();
    dividend_i = 16'd65535;
    tag_i      = 4'hA;
    wait_valid(n);
    check("hold latency", 32'(n), 32'd3);
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("hold%0d out_valid", c), 32'(out_valid_o), 32'd1);
      check($sformatf("hold%0d in_ready", c), 32'(in_ready_o), 32'd0);
      check($sformatf("hold%0d quotient", c), 32'(quotient_o), 32'd123);
      check($sformatf("hold%0d remainder", c), 32'(remainder_o), 32'd4);
      check($sformatf("hold%0d tag", c), 32'(tag_o), 32'h5);
    end
    out_ready_i = 1'b1;
    #1;
    check("handoff in_ready", 32'(in_ready_o), 32'd1);
    step();
    in_valid_i = 1'b0;
    check("handoff busy", 32'(out_valid_o), 32'd0);
    wait_valid(n);
    check("handoff latency", 32'(n), 32'd4);
    check("handoff quotient", 32'(quotient_o), 32'd6553);
    check("handoff remainder", 32'(remainder_o), 32'd5);
    check("handoff tag", 32'(tag_o), 32'hA);
    step();

    // Flush in the second BUSY cycle, with a competing operand
    dividend_i = 16'd1234;
    tag_i      = 4'h3;
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    step();
    flush_i    = 1'b1;
    dividend_i = 16'd9;
    in_valid_i = 1'b1;
    #1;
    check("flush in_ready", 32'(in_ready_o), 32'd0);
    step();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid_o) n++;
      step();
    end
    check("flush no valid", 32'(n), 32'd0);
    check("flush kept quotient", 32'(quotient_o), 32'd6553);
    check("flush in_ready after", 32'(in_ready_o), 32'd1);

    // Reset mid-BUSY
    dividend_i = 16'd1234;
    tag_i      = 4'h7;
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    step();
    rst_ni = 1'b0;
    #1;
    check("midrst out_valid", 32'(out_valid_o), 32'd0);
    check("midrst quotient", 32'(quotient_o), 32'd0);
    step();
    rst_ni = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid_o) n++;
      step();
    end
    check("midrst no valid", 32'(n), 32'd0);
    check("midrst quotient after", 32'(quotient_o), 32'd0);
    check("midrst remainder after", 32'(remainder_o), 32'd0);
    check("midrst tag after", 32'(tag_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
